// File: rtl/seq_alu_exec.sv
// Sequential 32-bit ALU with a valid/ready handshake on both sides.
// Shifts execute one bit per cycle; all other operations finish in one cycle.
module seq_alu_exec #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   localparam int unsigned SHW = 5;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_SLT  = 4'h5;
   localparam logic [3:0] OP_SLTU = 4'h6;
   localparam logic [3:0] OP_SLL  = 4'h7;
   localparam logic [3:0] OP_SRL  = 4'h8;
   localparam logic [3:0] OP_SRA  = 4'h9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0]  res_d;
   logic             in_ready_d, out_valid_d;
   logic [XLEN-1:0]  alu_c;
   logic [SHW-1:0]   shamt_c;
   logic             is_shift_c;

   assign shamt_c    = src_b[SHW-1:0];
   assign is_shift_c = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);

   // Single-cycle result; shift ops pass src_a through (only used when shift amount is 0)
   always_comb begin
      alu_c = '0;
      case (alu_op)
         OP_ADD:  alu_c = src_a + src_b;
         OP_SUB:  alu_c = src_a - src_b;
         OP_AND:  alu_c = src_a & src_b;
         OP_OR:   alu_c = src_a | src_b;
         OP_XOR:  alu_c = src_a ^ src_b;
         OP_SLT:  alu_c = XLEN'($signed(src_a) < $signed(src_b));
         OP_SLTU: alu_c = XLEN'(src_a < src_b);
         OP_SLL, OP_SRL, OP_SRA: alu_c = src_a;
         default: alu_c = '0;
      endcase
   end

   // Next-state, shift datapath and registered-output next values
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      res_d   = result;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               op_d = alu_op;
               if (is_shift_c && (shamt_c != '0)) begin
                  state_d = SHIFT;
                  cnt_d   = shamt_c;
                  res_d   = src_a;
               end else begin
                  state_d = DONE;
                  res_d   = alu_c;
               end
            end
         end
         SHIFT: begin
            cnt_d = cnt_q - SHW'(1);
            case (op_q)
               OP_SLL:  res_d = {result[XLEN-2:0], 1'b0};
               OP_SRL:  res_d = {1'b0, result[XLEN-1:1]};
               default: res_d = {result[XLEN-1], result[XLEN-1:1]};
            endcase
            // The last shift step lands in DONE with the counter at zero
            if (cnt_q <= SHW'(1)) begin
               state_d = DONE;
               cnt_d   = '0;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= OP_ADD;
         cnt_q     <= '0;
         result    <= '0;
         zero      <= 1'b1;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         result    <= res_d;
         zero      <= (res_d == '0);
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
      end
   end

endmodule
